axi_arbiter: RTL and testbench

- Sequences and shares one AXI4 master port between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the core's fetch/LSU stages and the SoC AXI bus.
- Each requester uses a simple req/gnt/done interface. The arbiter owns all AXI handshakes, issues single-beat transactions only, and keeps at most one transaction outstanding.

---
 rtl/axi_arbiter.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter.sv
// axi_arbiter: round-robin sharing of one single-beat AXI4 master port
// between IFU (read-only) and LSU. Define AXI_ARB_TIMEOUT_EN for the watchdog.
module axi_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_gnt,
    output logic                ifu_done,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_resp,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [2:0]          lsu_size,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_gnt,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_resp,
    output logic                io_master_awvalid,
    input  logic                io_master_awready,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [3:0]          io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    output logic                io_master_wvalid,
    input  logic                io_master_wready,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    output logic                io_master_bready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [3:0]          io_master_bid,
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [3:0]          io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    output logic                io_master_rready,
    input  logic                io_master_rvalid,
    input  logic [1:0]          io_master_rresp,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic                io_master_rlast,
    input  logic [3:0]          io_master_rid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_AR,
        S_RD_R,
        S_WR_AW_W,
        S_WR_B
    } state_e;

    state_e              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic                owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                ifu_done_q, ifu_done_d;
    logic                lsu_done_q, lsu_done_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic [1:0]          ifu_resp_q, ifu_resp_d;
    logic [1:0]          lsu_resp_q, lsu_resp_d;

    logic                pick_lsu;
    logic [1:0]          r_resp;
    logic                timeout;
    logic                unused_ok;

    // bid carries no information for a single-ID write stream
    assign unused_ok = ^{io_master_bid, 32'(TIMEOUT_CYCLES)};

`ifdef AXI_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign timeout = (state_q != S_IDLE) &&
                     (cnt_q == 16'(TIMEOUT_CYCLES));

    // Watchdog restarts on every state change, idles at zero
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (state_q == S_IDLE || state_d != state_q) begin
            cnt_d = 16'd0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = 4'd1;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = 2'b01;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = {3'b000, owner_lsu_q};
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = 2'b01;

    assign ifu_done  = ifu_done_q;
    assign lsu_done  = lsu_done_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign ifu_resp  = ifu_resp_q;
    assign lsu_resp  = lsu_resp_q;

    // Arbitration, AXI channel sequencing and response capture
    always_comb begin
        state_d           = state_q;
        last_lsu_d        = last_lsu_q;
        owner_lsu_d       = owner_lsu_q;
        addr_d            = addr_q;
        size_d            = size_q;
        wdata_d           = wdata_q;
        wstrb_d           = wstrb_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        ifu_done_d        = 1'b0;
        lsu_done_d        = 1'b0;
        ifu_rdata_d       = ifu_rdata_q;
        lsu_rdata_d       = lsu_rdata_q;
        ifu_resp_d        = ifu_resp_q;
        lsu_resp_d        = lsu_resp_q;
        ifu_gnt           = 1'b0;
        lsu_gnt           = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        pick_lsu          = lsu_req & (~ifu_req | ~last_lsu_q);
        r_resp            = io_master_rresp;

        if (io_master_rid != {3'b000, owner_lsu_q} || !io_master_rlast) begin
            r_resp = 2'b10;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ifu_req || lsu_req) begin
                    owner_lsu_d = pick_lsu;
                    last_lsu_d  = pick_lsu;
                    addr_d      = pick_lsu ? lsu_addr : ifu_addr;
                    size_d      = pick_lsu ? lsu_size : 3'b010;
                    wdata_d     = lsu_wdata;
                    wstrb_d     = lsu_wstrb;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    ifu_gnt     = ~pick_lsu;
                    lsu_gnt     = pick_lsu;
                    state_d     = (pick_lsu && lsu_we) ? S_WR_AW_W : S_RD_AR;
                end
            end
            S_RD_AR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    state_d = S_RD_R;
                end
            end
            S_RD_R: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    if (owner_lsu_q) begin
                        lsu_rdata_d = io_master_rdata;
                        lsu_resp_d  = r_resp;
                        lsu_done_d  = 1'b1;
                    end else begin
                        ifu_rdata_d = io_master_rdata;
                        ifu_resp_d  = r_resp;
                        ifu_done_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_WR_AW_W: begin
                io_master_awvalid = ~aw_done_q;
                io_master_wvalid  = ~w_done_q;
                aw_done_d = aw_done_q | io_master_awready;
                w_done_d  = w_done_q | io_master_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_B;
                end
            end
            S_WR_B: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    lsu_resp_d = io_master_bresp;
                    lsu_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled slave is abandoned: no valid/ready, DECERR to the owner
        if (timeout) begin
            io_master_arvalid = 1'b0;
            io_master_rready  = 1'b0;
            io_master_awvalid = 1'b0;
            io_master_wvalid  = 1'b0;
            io_master_bready  = 1'b0;
            state_d           = S_IDLE;
            if (owner_lsu_q) begin
                lsu_rdata_d = '0;
                lsu_resp_d  = 2'b11;
                lsu_done_d  = 1'b1;
            end else begin
                ifu_rdata_d = '0;
                ifu_resp_d  = 2'b11;
                ifu_done_d  = 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_lsu_q  <= 1'b0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ifu_done_q  <= 1'b0;
            lsu_done_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_resp_q  <= 2'b00;
            lsu_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ifu_done_q  <= ifu_done_d;
            lsu_done_q  <= lsu_done_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed plus randomized transactions against a
// transaction-level model of the round-robin single-beat arbiter.
`timescale 1ns/1ps
module tb_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt, ifu_done;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_resp;
    logic        lsu_req, lsu_we;
    logic [31:0] lsu_addr;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_gnt, lsu_done;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_resp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    int vectors = 0;
    int miscompares = 0;

    // model: round-robin memory of the last winner (1 = LSU)
    bit last_lsu;
    // slave behaviour for the next transaction
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [31:0] r_data;
    logic [1:0]  r_resp, b_resp;
    bit          r_bad, r_last;

    always #5 clock = ~clock;

    axi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr),
        .ifu_gnt(ifu_gnt), .ifu_done(ifu_done),
        .ifu_rdata(ifu_rdata), .ifu_resp(ifu_resp),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_gnt(lsu_gnt), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .lsu_resp(lsu_resp),
        .io_master_awvalid(awvalid), .io_master_awready(awready),
        .io_master_awaddr(awaddr), .io_master_awid(awid),
        .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wvalid(wvalid), .io_master_wready(wready),
        .io_master_wdata(wdata), .io_master_wstrb(wstrb),
        .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid),
        .io_master_bresp(bresp), .io_master_bid(bid),
        .io_master_arvalid(arvalid), .io_master_arready(arready),
        .io_master_araddr(araddr), .io_master_arid(arid),
        .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid),
        .io_master_rresp(rresp), .io_master_rdata(rdata),
        .io_master_rlast(rlast), .io_master_rid(rid)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 128'({ifu_gnt, lsu_gnt, ifu_done, lsu_done}), 128'(0));
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 128'({ifu_gnt, lsu_gnt, ifu_done, lsu_done, arvalid,
                       awvalid, wvalid, rready, bready}), 128'(0));
    endtask

    task automatic post_ifu(input logic [31:0] a);
        if (!ifu_req) begin
            ifu_addr = a;
            ifu_req  = 1'b1;
        end
    endtask

    task automatic post_lsu(input bit we, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] wd,
                            input logic [3:0] ws);
        if (!lsu_req) begin
            lsu_we    = we;
            lsu_addr  = a;
            lsu_size  = sz;
            lsu_wdata = wd;
            lsu_wstrb = ws;
            lsu_req   = 1'b1;
        end
    endtask

    task automatic rand_slave();
        ar_wait = $urandom_range(0, 3);
        r_wait  = $urandom_range(0, 2);
        aw_wait = $urandom_range(0, 3);
        w_wait  = $urandom_range(0, 3);
        b_wait  = $urandom_range(0, 2);
        r_data  = $urandom;
        r_resp  = 2'($urandom_range(0, 3));
        b_resp  = 2'($urandom_range(0, 3));
        r_bad   = ($urandom_range(0, 7) == 0);
        r_last  = ($urandom_range(0, 7) != 0);
    endtask

    // One full transaction starting in a cycle where the arbiter is idle
    task automatic serve();
        bit          wl, we, awdn, wdn;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        logic [3:0]  ws, id;
        logic [1:0]  er;
        #1;
        wl = (ifu_req && lsu_req) ? !last_lsu : lsu_req;
        chk("gnt", 128'({ifu_gnt, lsu_gnt}), 128'({!wl, wl}));
        last_lsu = wl;
        we = wl && lsu_we;
        a  = wl ? lsu_addr : ifu_addr;
        sz = wl ? lsu_size : 3'd2;
        id = {3'b000, wl};
        wd = lsu_wdata;
        ws = lsu_wstrb;
        step();
        if (wl) lsu_req = 1'b0;
        else    ifu_req = 1'b0;
        if (!we) begin
            for (int k = 0; k <= ar_wait; k++) begin
                arready = (k == ar_wait);
                #1;
                chk("ar", 128'({arvalid, araddr, arid, arsize, arlen,
                               arburst, rready}),
                    128'({1'b1, a, id, sz, 8'd0, 2'b01, 1'b0}));
                chk_quiet("ar_quiet");
                step();
            end
            arready = 1'b0;
            for (int k = 0; k <= r_wait; k++) begin
                rvalid = (k == r_wait);
                rdata  = r_data;
                rresp  = r_resp;
                rlast  = r_last;
                rid    = r_bad ? (id ^ 4'd1) : id;
                #1;
                chk("r", 128'({rready, arvalid}), 128'(2'b10));
                chk_quiet("r_quiet");
                step();
            end
            rvalid = 1'b0;
            er = (r_bad || !r_last) ? 2'b10 : r_resp;
            #1;
            if (wl)
                chk("lsu_rd_done", 128'({ifu_done, lsu_done, lsu_rdata,
                                        lsu_resp}),
                    128'({1'b0, 1'b1, r_data, er}));
            else
                chk("ifu_rd_done", 128'({ifu_done, lsu_done, ifu_rdata,
                                        ifu_resp}),
                    128'({1'b1, 1'b0, r_data, er}));
        end else begin
            awdn = 1'b0;
            wdn  = 1'b0;
            for (int k = 0; !(awdn && wdn); k++) begin
                awready = (k == aw_wait);
                wready  = (k == w_wait);
                #1;
                if (awdn)
                    chk("aw_drop", 128'(awvalid), 128'(0));
                else
                    chk("aw", 128'({awvalid, awaddr, awid, awsize, awlen,
                                   awburst}),
                        128'({1'b1, a, 4'd1, sz, 8'd0, 2'b01}));
                if (wdn)
                    chk("w_drop", 128'(wvalid), 128'(0));
                else
                    chk("w", 128'({wvalid, wdata, wstrb, wlast}),
                        128'({1'b1, wd, ws, 1'b1}));
                chk("aw_bready", 128'(bready), 128'(0));
                chk_quiet("aw_quiet");
                if (k == aw_wait) awdn = 1'b1;
                if (k == w_wait)  wdn  = 1'b1;
                step();
            end
            awready = 1'b0;
            wready  = 1'b0;
            for (int k = 0; k <= b_wait; k++) begin
                bvalid = (k == b_wait);
                bresp  = b_resp;
                bid    = 4'd1;
                #1;
                chk("b", 128'({bready, awvalid, wvalid}), 128'(3'b100));
                chk_quiet("b_quiet");
                step();
            end
            bvalid = 1'b0;
            #1;
            chk("wr_done", 128'({ifu_done, lsu_done, lsu_resp}),
                128'({1'b0, 1'b1, b_resp}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ifu_req = 0; ifu_addr = 0;
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_size = 0;
        lsu_wdata = 0; lsu_wstrb = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0; rid = 0;
        last_lsu = 1'b0;

        // reset hold then quiet idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("rst_ctl");
            chk("rst_regs", 128'({ifu_rdata, lsu_rdata, ifu_resp, lsu_resp,
                                 araddr, awaddr}), 128'(0));
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle("idle20");
        end

        // IFU fetch from a zero-wait slave
        rand_slave();
        ar_wait = 0; r_wait = 0; r_data = 32'h0000_0413;
        r_resp = 2'b00; r_bad = 0; r_last = 1;
        post_ifu(32'h8000_0000);
        serve();

        // LSU write with W accepted 3 cycles after AW
        rand_slave();
        aw_wait = 0; w_wait = 3; b_wait = 1; b_resp = 2'b00;
        post_lsu(1'b1, 32'h8000_0100, 3'd2, 32'hDEAD_BEEF, 4'b0011);
        serve();
        step();
        chk("single_done", 128'({lsu_done, ifu_done}), 128'(0));

        // back-to-back ties alternate
        for (int i = 0; i < 4; i++) begin
            rand_slave();
            post_ifu($urandom);
            post_lsu(1'b0, $urandom, 3'd2, 32'd0, 4'd0);
            serve();
        end
        rand_slave();
        serve();

        // LSU byte read answered with the wrong ID
        rand_slave();
        r_bad = 1; r_last = 1; r_resp = 2'b00;
        post_lsu(1'b0, 32'h8000_0003, 3'd0, 32'd0, 4'd0);
        serve();

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            if (!ifu_req && !lsu_req && $urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 1 + int'($urandom_range(0, 2)); j++) begin
                    step();
                    chk_idle("gap");
                end
            end
            if ($urandom_range(0, 1) == 1) post_ifu($urandom);
            if ($urandom_range(0, 1) == 1)
                post_lsu(1'($urandom), $urandom, 3'($urandom_range(0, 2)),
                         $urandom, 4'($urandom));
            if (!ifu_req && !lsu_req) post_ifu($urandom);
            rand_slave();
            serve();
        end
        while (ifu_req || lsu_req) begin
            rand_slave();
            serve();
        end

        // asynchronous reset in the middle of a read
        step();
        post_ifu(32'h8000_0040);
        #1;
        chk("mr_gnt", 128'({ifu_gnt, lsu_gnt}), 128'(2'b10));
        step();
        ifu_req = 1'b0;
        #1;
        chk("mr_ar", 128'(arvalid), 128'(1));
        reset = 1'b0;
        #1;
        chk_idle("mr_rst");
        chk("mr_regs", 128'({ifu_rdata, lsu_rdata, ifu_resp, lsu_resp,
                            araddr}), 128'(0));
        last_lsu = 1'b0;
        step();
        reset = 1'b1;
        step();
        rand_slave();
        post_ifu($urandom);
        post_lsu(1'b0, $urandom, 3'd1, 32'd0, 4'd0);
        serve();
        rand_slave();
        serve();

`ifdef AXI_ARB_TIMEOUT_EN
        // stuck AR channel hits the watchdog
        step();
        post_lsu(1'b0, 32'h8000_0200, 3'd2, 32'd0, 4'd0);
        #1;
        chk("to_gnt", 128'({ifu_gnt, lsu_gnt}), 128'(2'b01));
        last_lsu = 1'b1;
        step();
        lsu_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("to_ar", 128'(arvalid), 128'(1));
            step();
        end
        #1;
        chk("to_drop", 128'({arvalid, rready}), 128'(0));
        step();
        chk("to_done", 128'({lsu_done, lsu_rdata, lsu_resp}),
            128'({1'b1, 32'd0, 2'b11}));
        rand_slave();
        post_ifu($urandom);
        serve();
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
